// File: rtl/paddle_quad_pkg.sv
// Shared types and helpers for the paddle quadrature controller:
// FSM states, signed step direction and the Gray phase sequencer.
package paddle_quad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MOVE     = 2'd1,
        ST_HANDOVER = 2'd2
    } state_e;

    typedef logic signed [1:0] dir_t;

    localparam dir_t DIR_NONE = 2'sb00;
    localparam dir_t DIR_POS  = 2'sb01;
    localparam dir_t DIR_NEG  = 2'sb11;

    typedef struct packed {
        logic left;
        logic right;
    } paddle_req_t;

    // Both-pressed collapses to idle so a rocking thumb cannot jitter the encoder.
    function automatic dir_t req_dir(paddle_req_t req);
        dir_t d;
        case ({req.left, req.right})
            2'b01:   d = DIR_POS;
            2'b10:   d = DIR_NEG;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; one bit flips per step.
    function automatic logic [1:0] quad_next(logic [1:0] phase, dir_t dir);
        logic [1:0] fwd;
        logic [1:0] rev;
        logic [1:0] nxt;
        case (phase)
            2'b00:   begin fwd = 2'b01; rev = 2'b10; end
            2'b01:   begin fwd = 2'b11; rev = 2'b00; end
            2'b11:   begin fwd = 2'b10; rev = 2'b01; end
            default: begin fwd = 2'b00; rev = 2'b11; end
        endcase
        if (dir == DIR_POS) begin
            nxt = fwd;
        end else if (dir == DIR_NEG) begin
            nxt = rev;
        end else begin
            nxt = phase;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/paddle_quad_ctrl_stepper.sv
// Holds the encoder phase and advances it one Gray step per strobe.
module quad_stepper
    import paddle_quad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  dir_t       dir,
    output logic [1:0] steer
);

    logic [1:0] steer_q;
    logic [1:0] steer_d;

    always_comb begin
        steer_d = steer_q;
        if (step) begin
            steer_d = quad_next(steer_q, dir);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            steer_q <= 2'b00;
        end else begin
            steer_q <= steer_d;
        end
    end

    assign steer = steer_q;

endmodule

// File: rtl/paddle_quad_ctrl.sv
// Single shared paddle encoder: picks the owning player, ramps the step rate
// and guards player handovers so the core never sees a phase jump.
module paddle_quad_ctrl
    import paddle_quad_pkg::*;
#(
    parameter int unsigned CLKDIV_SLOW  = 5500,
    parameter int unsigned CLKDIV_FAST  = 1375,
    parameter int unsigned RAMP_STEPS   = 8,
    parameter int unsigned SWITCH_GUARD = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       left0,
    input  logic       right0,
    input  logic       left1,
    input  logic       right1,
    input  logic       active_player,
    input  logic       freeze,
    output logic [1:0] steer,
    output logic       owner,
    output logic       moving
);

    localparam int unsigned CNT_W   = $clog2(CLKDIV_SLOW);
    localparam int unsigned RAMP_W  = $clog2(RAMP_STEPS + 1);
    localparam int unsigned GUARD_W = $clog2(SWITCH_GUARD);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RAMP_W-1:0]   ramp_q, ramp_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    dir_t                dir_q, dir_d;
    logic                owner_q, owner_d;
    logic                moving_q, moving_d;

    paddle_req_t         req_c;
    dir_t                dir_c;
    logic                handover_c;
    logic                ramp_full_c;
    logic [CNT_W-1:0]    div_m1_c;
    logic                step_c;

    // Request of whichever player currently owns the encoder.
    always_comb begin
        req_c.left  = owner_q ? left1  : left0;
        req_c.right = owner_q ? right1 : right0;
        dir_c       = req_dir(req_c);
        handover_c  = (active_player != owner_q) && (state_q != ST_HANDOVER);
        ramp_full_c = (ramp_q == RAMP_W'(RAMP_STEPS));
        div_m1_c    = ramp_full_c ? CNT_W'(CLKDIV_FAST - 1) : CNT_W'(CLKDIV_SLOW - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ramp_d  = ramp_q;
        guard_d = guard_q;
        dir_d   = dir_q;
        owner_d = owner_q;
        step_c  = 1'b0;

        if (freeze) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ramp_d  = '0;
            guard_d = '0;
        end else if (handover_c) begin
            state_d = ST_HANDOVER;
            guard_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dir_c != DIR_NONE) begin
                        state_d = ST_MOVE;
                        cnt_d   = '0;
                        dir_d   = dir_c;
                    end
                end
                ST_MOVE: begin
                    if (dir_c == DIR_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        ramp_d  = '0;
                    end else if (dir_c != dir_q) begin
                        // Reversal restarts the slow rate without stepping.
                        dir_d  = dir_c;
                        cnt_d  = '0;
                        ramp_d = '0;
                    end else if (cnt_q == div_m1_c) begin
                        step_c = 1'b1;
                        cnt_d  = '0;
                        ramp_d = ramp_full_c ? ramp_q : ramp_q + RAMP_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HANDOVER: begin
                    if (guard_q == GUARD_W'(SWITCH_GUARD - 1)) begin
                        owner_d = active_player;
                        state_d = ST_IDLE;
                        ramp_d  = '0;
                        guard_d = '0;
                    end else begin
                        guard_d = guard_q + GUARD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        moving_d = (state_d == ST_MOVE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ramp_q   <= '0;
            guard_q  <= '0;
            dir_q    <= DIR_NONE;
            owner_q  <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ramp_q   <= ramp_d;
            guard_q  <= guard_d;
            dir_q    <= dir_d;
            owner_q  <= owner_d;
            moving_q <= moving_d;
        end
    end

    quad_stepper u_stepper (
        .clk   (CLK),
        .reset (RESET),
        .step  (step_c),
        .dir   (dir_q),
        .steer (steer)
    );

    assign owner  = owner_q;
    assign moving = moving_q;

endmodule

// File: tb/tb_paddle_quad_ctrl.sv
// Directed scenarios plus randomized traffic against a positional reference model.
module tb_paddle_quad_ctrl;

    localparam int SLOW  = 8;
    localparam int FAST  = 2;
    localparam int RAMP  = 3;
    localparam int GUARD = 4;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_HAND = 2;

    logic       CLK;
    logic       RESET;
    logic       left0, right0, left1, right1;
    logic       active_player;
    logic       freeze;
    logic [1:0] steer;
    logic       owner;
    logic       moving;

    int total = 0;
    int bad   = 0;

    // Reference model: encoder position as an integer around a 4-entry Gray wheel.
    int m_pos, m_owner, m_mode, m_cnt, m_ramp, m_guard, m_dir;
    logic [1:0] gray_tab [4];

    paddle_quad_ctrl #(
        .CLKDIV_SLOW  (SLOW),
        .CLKDIV_FAST  (FAST),
        .RAMP_STEPS   (RAMP),
        .SWITCH_GUARD (GUARD)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .left0         (left0),
        .right0        (right0),
        .left1         (left1),
        .right1        (right1),
        .active_player (active_player),
        .freeze        (freeze),
        .steer         (steer),
        .owner         (owner),
        .moving        (moving)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dir_of(input logic l, input logic r);
        if (r && !l) return 1;
        if (l && !r) return -1;
        return 0;
    endfunction

    task automatic model_edge();
        int d;
        int div;
        d   = (m_owner != 0) ? dir_of(left1, right1) : dir_of(left0, right0);
        div = (m_ramp == RAMP) ? FAST : SLOW;
        if (RESET) begin
            m_pos = 0; m_owner = 0; m_mode = M_IDLE;
            m_cnt = 0; m_ramp = 0; m_guard = 0; m_dir = 0;
        end else if (freeze) begin
            m_mode = M_IDLE; m_cnt = 0; m_ramp = 0; m_guard = 0;
        end else if (int'(active_player) != m_owner && m_mode != M_HAND) begin
            m_mode = M_HAND; m_guard = 0; m_cnt = 0;
        end else if (m_mode == M_IDLE) begin
            if (d != 0) begin
                m_mode = M_MOVE; m_cnt = 0; m_dir = d;
            end
        end else if (m_mode == M_MOVE) begin
            if (d == 0) begin
                m_mode = M_IDLE; m_cnt = 0; m_ramp = 0;
            end else if (d == -m_dir) begin
                m_dir = d; m_cnt = 0; m_ramp = 0;
            end else if (m_cnt + 1 == div) begin
                m_pos = (m_pos + d + 4) % 4;
                m_cnt = 0;
                if (m_ramp < RAMP) m_ramp++;
            end else begin
                m_cnt++;
            end
        end else begin
            if (m_guard + 1 == GUARD) begin
                m_owner = int'(active_player);
                m_mode  = M_IDLE;
                m_ramp  = 0;
                m_guard = 0;
            end else begin
                m_guard++;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("steer",  32'(steer),  32'(gray_tab[m_pos]));
        check("owner",  32'(owner),  32'(m_owner));
        check("moving", 32'(moving), 32'(m_mode == M_MOVE));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        {left0, right0, left1, right1} = 4'b0000;
        active_player = 1'b0;
        freeze = 1'b0;
        tick_n(2);
        RESET = 1'b0;
    endtask

    initial begin
        gray_tab[0] = 2'b00; gray_tab[1] = 2'b01;
        gray_tab[2] = 2'b11; gray_tab[3] = 2'b10;
        m_pos = 0; m_owner = 0; m_mode = M_IDLE;
        m_cnt = 0; m_ramp = 0; m_guard = 0; m_dir = 0;

        // Reset values, then ramp from slow to fast rate
        do_reset();
        check("rst_steer",  32'(steer),  32'h0);
        check("rst_owner",  32'(owner),  32'h0);
        check("rst_moving", 32'(moving), 32'h0);
        tick_n(3);
        right0 = 1'b1;
        tick();
        check("ramp_entry_moving", 32'(moving), 32'h1);
        tick_n(7);
        check("ramp_pre_step", 32'(steer), 32'h0);
        tick();
        check("ramp_s1", 32'(steer), 32'h1);
        tick_n(8);
        check("ramp_s2", 32'(steer), 32'h3);
        tick_n(8);
        check("ramp_s3", 32'(steer), 32'h2);
        tick_n(2);
        check("ramp_fast1", 32'(steer), 32'h0);
        tick_n(2);
        check("ramp_fast2", 32'(steer), 32'h1);

        // Both directions pressed counts as idle
        do_reset();
        {left0, right0} = 2'b11;
        tick_n(100);
        check("both_steer",  32'(steer),  32'h0);
        check("both_moving", 32'(moving), 32'h0);

        // Reversal clears ramp and skips the reversal-edge step
        do_reset();
        right0 = 1'b1;
        tick();
        tick_n(16);
        check("rev_before", 32'(steer), 32'h3);
        right0 = 1'b0; left0 = 1'b1;
        tick();
        check("rev_edge", 32'(steer), 32'h3);
        tick_n(7);
        check("rev_wait", 32'(steer), 32'h3);
        tick();
        check("rev_step", 32'(steer), 32'h1);

        // Player handover with guard interval
        do_reset();
        right0 = 1'b1;
        tick();
        tick_n(10);
        check("ho_pre", 32'(steer), 32'h1);
        active_player = 1'b1;
        tick();
        check("ho_req_owner", 32'(owner), 32'h0);
        check("ho_req_steer", 32'(steer), 32'h1);
        tick_n(3);
        check("ho_guard_owner", 32'(owner), 32'h0);
        tick();
        check("ho_done_owner", 32'(owner), 32'h1);
        check("ho_done_steer", 32'(steer), 32'h1);
        tick_n(20);
        check("ho_p0_ignored", 32'(steer), 32'h1);
        check("ho_p0_moving",  32'(moving), 32'h0);
        right1 = 1'b1;
        tick();
        tick_n(7);
        check("ho_p1_wait", 32'(steer), 32'h1);
        tick();
        check("ho_p1_step", 32'(steer), 32'h3);

        // Freeze mid-move, then resume
        do_reset();
        right0 = 1'b1;
        tick();
        tick_n(16);
        freeze = 1'b1;
        tick();
        check("frz_steer",  32'(steer),  32'h3);
        check("frz_moving", 32'(moving), 32'h0);
        tick_n(5);
        check("frz_hold", 32'(steer), 32'h3);
        freeze = 1'b0;
        tick();
        tick_n(7);
        check("frz_wait", 32'(steer), 32'h3);
        tick();
        check("frz_step", 32'(steer), 32'h2);

        // Reset during handover
        active_player = 1'b1;
        tick_n(2);
        RESET = 1'b1;
        tick();
        check("rho_steer",  32'(steer),  32'h0);
        check("rho_owner",  32'(owner),  32'h0);
        check("rho_moving", 32'(moving), 32'h0);
        RESET = 1'b0;
        active_player = 1'b0;
        right0 = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0)
                {left0, right0, left1, right1} = 4'($urandom);
            if ($urandom_range(0, 199) == 0)
                active_player = ~active_player;
            if (!freeze && $urandom_range(0, 299) == 0)
                freeze = 1'b1;
            else if (freeze && $urandom_range(0, 7) == 0)
                freeze = 1'b0;
            RESET = ($urandom_range(0, 1999) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
